// File: rtl/dd_cmd_sequencer.sv
// 64DD command sequencer: latches N64 PI register writes and runs the cmd_request/cmd_ack handshake to the CPU side.
// Optional WAIT_ACK timeout abort is compiled in with `define DD_CMD_TIMEOUT_EN.
module dd_cmd_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter int unsigned BUSY_BIT       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        n64_cmd_write,
    input  logic [7:0]  n64_cmd_data,
    input  logic        n64_data_write,
    input  logic [15:0] n64_data_data,
    input  logic        n64_bm_write,
    input  logic [15:0] n64_bm_data,
    input  logic        n64_hard_reset,
    input  logic        n64_irq_clear,
    output logic [15:0] n64_status,
    output logic        irq,
    output logic        overrun,
    output logic        timeout,
    input  logic        cpu_cmd_ack,
    input  logic [15:0] cpu_status,
    output logic        cmd_request,
    output logic [7:0]  command,
    output logic [15:0] data_input,
    output logic        bm_request,
    output logic [15:0] bm_control,
    output logic        hard_reset
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] TIMED_OUT = 2'd2;

    logic [1:0] state;
    logic       cmd_accept;
    logic       cmd_overrun;
    logic       hr_abort;
    logic       ack_done;
    logic       timeout_hit;

    assign cmd_accept  = (state == IDLE) && n64_cmd_write && !hard_reset;
    assign cmd_overrun = (state != IDLE) && n64_cmd_write && !hard_reset;
    // Abort on the incoming rise as well as while held, so a command accepted
    // in the same cycle the reset input rises cannot get stranded in WAIT_ACK.
    assign hr_abort    = (state == WAIT_ACK) && (n64_hard_reset || hard_reset);
    assign ack_done    = (state == WAIT_ACK) && cpu_cmd_ack && !hr_abort;

`ifdef DD_CMD_TIMEOUT_EN
    logic [23:0] wait_cnt;

    assign timeout_hit = (state == WAIT_ACK) && !hr_abort && !cpu_cmd_ack &&
                         (wait_cnt == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (cmd_accept)
                wait_cnt <= '0;
            else if (state == WAIT_ACK)
                wait_cnt <= wait_cnt + 24'd1;

            if (cmd_accept)
                timeout <= 1'b0;
            else if (timeout_hit)
                timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_request <= 1'b0;
            command     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_accept) begin
                        state       <= WAIT_ACK;
                        cmd_request <= 1'b1;
                        command     <= n64_cmd_data;
                    end
                end
                WAIT_ACK: begin
                    if (hr_abort || ack_done) begin
                        state       <= IDLE;
                        cmd_request <= 1'b0;
                    end else if (timeout_hit) begin
                        state       <= TIMED_OUT;
                        cmd_request <= 1'b0;
                    end
                end
                TIMED_OUT: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    cmd_request <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_input <= '0;
            bm_request <= 1'b0;
            bm_control <= '0;
            hard_reset <= 1'b0;
            irq        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            hard_reset <= n64_hard_reset;

            if ((state == IDLE) && n64_data_write)
                data_input <= n64_data_data;

            bm_request <= n64_bm_write && !hard_reset;
            if (n64_bm_write && !hard_reset)
                bm_control <= n64_bm_data;

            // A completion in the same cycle as a clear leaves irq set.
            if (ack_done || timeout_hit)
                irq <= 1'b1;
            else if (n64_irq_clear)
                irq <= 1'b0;

            if (cmd_overrun)
                overrun <= 1'b1;
            else if (n64_irq_clear)
                overrun <= 1'b0;
        end
    end

    always_comb begin
        n64_status = cpu_status;
        if (state != IDLE)
            n64_status[BUSY_BIT] = 1'b1;
    end

endmodule

// File: doc/dd_cmd_sequencer.md
Name: dd_cmd_sequencer

Overview:
- Sequences the 64DD register interface between the N64 PI register-write side and the CPU-side DD handler.
- Latches N64 command, data and buffer-manager writes, then drives the cmd_request/cmd_ack handshake toward the CPU.
- Owns busy/IRQ/overrun flags and hard-reset abort handling.
- Sits between the N64 bus register decoder and the DD interface bundle.

Parameters:
- TIMEOUT_CYCLES, 24'd10_000_000, cycles in WAIT_ACK before a command is aborted (used only with DD_CMD_TIMEOUT_EN).
- BUSY_BIT, 6, bit index in n64_status forced to 1 while a command is in flight.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- n64_cmd_write  in  1  one-cycle strobe: N64 wrote the command register
- n64_cmd_data  in  8  command byte, valid with n64_cmd_write
- n64_data_write  in  1  one-cycle strobe: N64 wrote the data register
- n64_data_data  in  16  data word, valid with n64_data_write
- n64_bm_write  in  1  one-cycle strobe: N64 wrote the BM control register
- n64_bm_data  in  16  BM control word
- n64_hard_reset  in  1  level, N64 hard reset asserted
- n64_irq_clear  in  1  one-cycle strobe: clear irq and overrun
- n64_status  out  16  status presented to N64 reads
- irq  out  1  command-complete interrupt, level
- overrun  out  1  a command write arrived while busy
- timeout  out  1  last command aborted by timeout
- cpu_cmd_ack  in  1  one-cycle strobe from CPU side
- cpu_status  in  16  status word from CPU side
- cmd_request  out  1  level, command pending to CPU
- command  out  8  latched command
- data_input  out  16  latched data word
- bm_request  out  1  one-cycle pulse on BM write
- bm_control  out  16  latched BM control
- hard_reset  out  1  registered copy of n64_hard_reset

Behaviour:
- Reset values: all outputs are 0. FSM is in IDLE.
- FSM states are IDLE, WAIT_ACK and TIMED_OUT.
- IDLE:
  - n64_cmd_write with hard_reset=0 latches command=n64_cmd_data and cmd_request=1 on the next edge. FSM moves to WAIT_ACK. Request latency is 1 cycle.
  - Clears the timeout flag on accept.
- WAIT_ACK:
  - cpu_cmd_ack → cmd_request=0 and irq=1 on the next edge; FSM returns to IDLE.
  - n64_cmd_write while in WAIT_ACK is ignored, command is unchanged, and overrun is set to 1.
  - Ack and a new cmd write in the same cycle: the ack completes, the write counts as overrun, and no new request is issued.
- cpu_cmd_ack while in IDLE is ignored.
- n64_data_write:
  - In IDLE, latches data_input.
  - In WAIT_ACK, it is ignored so data_input stays stable during the handshake; overrun is not set.
- n64_bm_write:
  - Latches bm_control and pulses bm_request high for exactly 1 cycle.
  - Back-to-back writes give back-to-back pulses, each with its own bm_control value.
  - Suppressed while hard_reset=1.
- hard_reset is registered from n64_hard_reset (1-cycle latency).
  - A rising edge while in WAIT_ACK aborts the command: cmd_request=0 and FSM→IDLE; irq is not set.
  - While hard_reset=1, cmd and bm writes are ignored and do not set overrun.
- n64_status = cpu_status with bit BUSY_BIT forced to 1 when state≠IDLE, otherwise passed through. This output is combinational.
- n64_irq_clear clears irq and overrun. If a completion and a clear happen in the same cycle, the completion wins and irq=1.
- Asynchronous reset mid-command returns to reset values immediately; no ack is expected afterward.

Optional Feature:
DD_CMD_TIMEOUT_EN.
- Defined:
  - A 24-bit counter is cleared on entering WAIT_ACK and increments each cycle in WAIT_ACK.
  - Reaching TIMEOUT_CYCLES-1 → cmd_request=0, timeout=1, irq=1, FSM→TIMED_OUT.
  - TIMED_OUT lasts 1 cycle, then FSM→IDLE.
  - An ack arriving in that same cycle is ignored.
- Undefined: no counter; WAIT_ACK waits indefinitely; the timeout output is tied to 0.

Test Plan:
- Cmd write 0x0C, ack 5 cycles later → cmd_request=1 one cycle after the write. n64_status[6]=1 during the wait. After the ack, cmd_request=0 and irq=1. n64_irq_clear → irq=0.
- Cmd 0x03, then cmd 0x08 while in WAIT_ACK → command stays 0x03, overrun=1. After ack, one irq and no second request.
- Data 0x1234 in IDLE, then 0xABCD during WAIT_ACK → data_input=0x1234 throughout.
- BM writes 0x0001, 0x0002 on consecutive cycles → two 1-cycle bm_request pulses with matching bm_control. The same writes with n64_hard_reset=1 → no pulses.
- Cmd 0x05, then n64_hard_reset rises before ack → cmd_request=0, FSM IDLE, irq=0. A later ack is ignored.
- With DD_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack → cmd_request falls 16 cycles after entering WAIT_ACK, with timeout=1 and irq=1. The next cmd write clears timeout.
